// File: rtl/trax_move_tx.sv
`default_nettype none
// ============================================================================
//  Module      : trax_move_tx
//  Description : Formats a Trax move word (tile type, column, row) into an
//                ASCII frame "<col><row><type>\n" and shifts it out on a UART
//                line, one start bit, eight data bits LSB first, one stop bit.
//                Optional macro TRAX_TX_PARITY_EN inserts an even-parity bit
//                (8E1) between the last data bit and the stop bit.
//  Revision    : 1.0  initial release
// ============================================================================
module trax_move_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_CHARS    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] move_in,
    input  logic        start_transmit,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int c_BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_PTR_W    = $clog2(MAX_CHARS + 1);
    localparam int c_IDX_W    = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int c_CAND_N   = 7;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST    = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_PRELAST = c_BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [c_PTR_W-1:0]  c_PTR_MAX      = c_PTR_W'(MAX_CHARS);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FMT_COL = 4'd1,
        S_FMT_ROW = 4'd2,
        S_LOAD    = 4'd3,
        S_START   = 4'd4,
        S_DATA    = 4'd5,
`ifdef TRAX_TX_PARITY_EN
        S_PARITY  = 4'd6,
`endif
        S_STOP    = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [21:0]           r_move;
    logic [7:0]            r_col0;
    logic [7:0]            r_col1;
    logic                  r_col_two;
    logic [9:0]            r_rem;
    logic [3:0]            r_hund;
    logic [3:0]            r_tens;
    logic [7:0]            r_buf [MAX_CHARS];
    logic [c_PTR_W-1:0]    r_len;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [7:0]            r_shift;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [3:0]            r_bit_cnt;
    logic                  r_err;
`ifdef TRAX_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic                  w_accept;
    logic                  w_req_valid;
    logic                  w_baud_last;
    logic                  w_more;
    logic [7:0]            w_type_char;
    logic [7:0]            w_cand    [c_CAND_N];
    logic                  w_cand_en [c_CAND_N];
    logic [7:0]            w_frame   [MAX_CHARS];
    logic [c_PTR_W-1:0]    w_len;

    assign w_accept    = start_transmit && (r_state == S_IDLE);
    assign w_req_valid = (move_in[21:20] != 2'b00) &&
                         (move_in[19:10] <= 10'd52) &&
                         (move_in[9:0]   <= 10'd999);
    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_more      = (r_rd_ptr < r_len);
    assign err         = r_err;

    // Tile type to its ASCII glyph
    always_comb begin
        w_type_char = 8'h2B;
        case (r_move[21:20])
            2'b01:   w_type_char = 8'h2B;
            2'b10:   w_type_char = 8'h2F;
            2'b11:   w_type_char = 8'h5C;
            default: w_type_char = 8'h2B;
        endcase
    end

    // Assemble the frame: column chars, row digits without leading zeros, type, LF
    always_comb begin
        w_cand[0]    = r_col0;
        w_cand_en[0] = 1'b1;
        w_cand[1]    = r_col1;
        w_cand_en[1] = r_col_two;
        w_cand[2]    = 8'h30 + {4'h0, r_hund};
        w_cand_en[2] = (r_hund != 4'd0);
        w_cand[3]    = 8'h30 + {4'h0, r_tens};
        w_cand_en[3] = (r_hund != 4'd0) || (r_tens != 4'd0);
        w_cand[4]    = 8'h30 + {4'h0, r_rem[3:0]};
        w_cand_en[4] = 1'b1;
        w_cand[5]    = w_type_char;
        w_cand_en[5] = 1'b1;
        w_cand[6]    = 8'h0A;
        w_cand_en[6] = 1'b1;
        for (int i = 0; i < MAX_CHARS; i++) begin
            w_frame[i] = 8'h00;
        end
        w_len = '0;
        for (int k = 0; k < c_CAND_N; k++) begin
            if (w_cand_en[k] && (w_len < c_PTR_MAX)) begin
                w_frame[w_len[c_IDX_W-1:0]] = w_cand[k];
                w_len = w_len + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and line/handshake outputs decoded from the current state
    always_comb begin
        w_state_next = r_state;
        tx           = 1'b1;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept && w_req_valid) begin
                    w_state_next = S_FMT_COL;
                end
            end
            S_FMT_COL: begin
                w_state_next = S_FMT_ROW;
            end
            S_FMT_ROW: begin
                if (r_rem < 10'd10) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (w_baud_last) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx = r_shift[r_bit_cnt[2:0]];
                if (w_baud_last && (r_bit_cnt == 4'd7)) begin
`ifdef TRAX_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef TRAX_TX_PARITY_EN
            S_PARITY: begin
                tx = r_parity;
                if (w_baud_last) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // The LOAD cycle supplies the final stop-bit clock so characters stay back to back
                if (w_more) begin
                    if (r_baud == c_BAUD_PRELAST) begin
                        w_state_next = S_LOAD;
                    end
                end else if (w_baud_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch request, format column/row, load and shift characters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_move    <= '0;
            r_col0    <= '0;
            r_col1    <= '0;
            r_col_two <= 1'b0;
            r_rem     <= '0;
            r_hund    <= '0;
            r_tens    <= '0;
            r_len     <= '0;
            r_rd_ptr  <= '0;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_err     <= 1'b0;
`ifdef TRAX_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
            for (int i = 0; i < MAX_CHARS; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            r_err <= w_accept && !w_req_valid;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_move <= move_in;
                    end
                end
                S_FMT_COL: begin
                    r_rem  <= r_move[9:0];
                    r_hund <= 4'd0;
                    r_tens <= 4'd0;
                    if (r_move[19:10] == 10'd0) begin
                        r_col0    <= 8'h40;
                        r_col_two <= 1'b0;
                    end else if (r_move[19:10] <= 10'd26) begin
                        r_col0    <= 8'h40 + r_move[17:10];
                        r_col_two <= 1'b0;
                    end else begin
                        r_col0    <= 8'h41;
                        r_col1    <= r_move[17:10] + 8'd38;
                        r_col_two <= 1'b1;
                    end
                end
                S_FMT_ROW: begin
                    if (r_rem >= 10'd100) begin
                        r_rem  <= r_rem - 10'd100;
                        r_hund <= r_hund + 1'b1;
                    end else if (r_rem >= 10'd10) begin
                        r_rem  <= r_rem - 10'd10;
                        r_tens <= r_tens + 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_CHARS; i++) begin
                            r_buf[i] <= w_frame[i];
                        end
                        r_len    <= w_len;
                        r_rd_ptr <= '0;
                    end
                end
                S_LOAD: begin
                    r_shift   <= r_buf[r_rd_ptr[c_IDX_W-1:0]];
`ifdef TRAX_TX_PARITY_EN
                    r_parity  <= ^r_buf[r_rd_ptr[c_IDX_W-1:0]];
`endif
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                end
                S_DATA: begin
                    r_baud <= w_baud_last ? '0 : r_baud + 1'b1;
                    if (w_baud_last) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_START,
`ifdef TRAX_TX_PARITY_EN
                S_PARITY,
`endif
                S_STOP: begin
                    r_baud <= w_baud_last ? '0 : r_baud + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trax_move_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trax_move_tx
//  Description : Self-checking bench for trax_move_tx. Random and directed
//                moves are compared against a frame model built from the
//                move-encoding rules; the serial line is recorded per cycle
//                and decoded at bit centres.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trax_move_tx;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
`ifdef TRAX_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LIMIT = 24 + 7 * NB * CPB + 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] move_in;
    logic        start_transmit;
    logic        tx;
    logic        busy;
    logic        done;
    logic        err;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    logic        tx_l   [0:1023];
    logic        busy_l [0:1023];

    trax_move_tx #(
        .CLKS_PER_BIT (CPB),
        .MAX_CHARS    (7)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .move_in        (move_in),
        .start_transmit (start_transmit),
        .tx             (tx),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected character list for a move; returns 0 when the move must be rejected
    function automatic bit build_expected(input logic [21:0] mv);
        int ty, col, row;
        ty  = int'(mv[21:20]);
        col = int'(mv[19:10]);
        row = int'(mv[9:0]);
        exp_q.delete();
        if (ty == 0 || col > 52 || row > 999) return 1'b0;
        if (col == 0)       exp_q.push_back(8'h40);
        else if (col <= 26) exp_q.push_back(8'(65 + col - 1));
        else begin
            exp_q.push_back(8'd65);
            exp_q.push_back(8'(65 + col - 27));
        end
        if (row >= 100) exp_q.push_back(8'(48 + row / 100));
        if (row >= 10)  exp_q.push_back(8'(48 + (row / 10) % 10));
        exp_q.push_back(8'(48 + row % 10));
        case (ty)
            1:       exp_q.push_back(8'h2B);
            2:       exp_q.push_back(8'h2F);
            default: exp_q.push_back(8'h5C);
        endcase
        exp_q.push_back(8'h0A);
        return 1'b1;
    endfunction

    // One request; poke_at re-pulses start mid-frame, rst_off resets that many cycles after the first start bit
    task automatic run_frame(input logic [21:0] mv, input int poke_at, input int rst_off);
        bit   valid;
        int   idx, s, d, n;
        logic ok;
        valid = build_expected(mv);
        move_in        = mv;
        start_transmit = 1'b1;
        step();
        start_transmit = 1'b0;
        move_in        = 22'($urandom);
        idx = 1;
        tx_l[1] = tx;
        busy_l[1] = busy;
        if (!valid) begin
            check("rej_err", err, 1);
            check("rej_busy", busy, 0);
            ok = 1'b1;
            for (int i = 0; i < 3 * CPB; i++) begin
                step();
                if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) ok = 1'b0;
            end
            check("rej_quiet", ok, 1);
            return;
        end
        check("acc_err", err, 0);
        s = -1;
        if (tx === 1'b0) s = 1;
        while (done !== 1'b1 && idx < LIMIT) begin
            start_transmit = (idx == poke_at);
            if (idx == poke_at) move_in = {2'b01, 10'd1, 10'd1};
            if (rst_off >= 0 && s > 0 && idx == s + rst_off) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check("rst_tx", tx, 1);
                check("rst_busy", busy, 0);
                ok = 1'b1;
                for (int i = 0; i < NB * CPB; i++) begin
                    step();
                    if (tx !== 1'b1 || done !== 1'b0) ok = 1'b0;
                end
                check("rst_quiet", ok, 1);
                return;
            end
            step();
            idx++;
            tx_l[idx] = tx;
            busy_l[idx] = busy;
            if (s < 0 && tx === 1'b0) s = idx;
        end
        start_transmit = 1'b0;
        if (done !== 1'b1 || s < 0) begin
            check("timeout", 0, 1);
            return;
        end
        d = idx;
        n = exp_q.size();
        check("first_start_le24", (s <= 24), 1);
        check("done_time", d, s + n * NB * CPB);
        check("busy_fall", busy, 0);
        ok = 1'b1;
        for (int i = 1; i < d; i++) if (busy_l[i] !== 1'b1) ok = 1'b0;
        for (int i = 1; i < s; i++) if (tx_l[i] !== 1'b1) ok = 1'b0;
        check("busy_idle_span", ok, 1);
        for (int k = 0; k < n; k++) begin
            logic [7:0] got;
            int         base;
            logic       frm;
            base = s + k * NB * CPB;
            frm  = (tx_l[base + HALF] === 1'b0) && (tx_l[base + (NB - 1) * CPB + HALF] === 1'b1);
            for (int j = 0; j < 8; j++) got[j] = tx_l[base + (1 + j) * CPB + HALF];
            check("char", got, exp_q[k]);
            check("framing", frm, 1);
`ifdef TRAX_TX_PARITY_EN
            check("parity", tx_l[base + 9 * CPB + HALF], ^exp_q[k]);
`endif
        end
        step();
        check("done_pulse", done, 0);
        if (poke_at >= 0) begin
            ok = 1'b1;
            for (int i = 0; i < 2 * NB * CPB; i++) begin
                step();
                if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
            end
            check("no_queue", ok, 1);
        end
    endtask

    initial begin
        logic [21:0] mv;
        reset          = 1'b1;
        move_in        = '0;
        start_transmit = 1'b0;
        repeat (3) step();
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);

        // reset wins over a simultaneous request
        move_in        = {2'b01, 10'd2, 10'd5};
        start_transmit = 1'b1;
        step();
        reset          = 1'b0;
        start_transmit = 1'b0;
        check("rst_prio_busy", busy, 0);
        step();
        check("rst_prio_idle", busy, 0);

        run_frame({2'b01, 10'd2,  10'd5},   -1, -1);
        run_frame({2'b10, 10'd0,  10'd0},   -1, -1);
        run_frame({2'b11, 10'd30, 10'd907}, 100, -1);
        run_frame({2'b00, 10'd1,  10'd1},   -1, -1);
        run_frame({2'b01, 10'd2,  10'd37},  -1, -1);
        run_frame({2'b01, 10'd27, 10'd123}, -1, NB * CPB + 4 * CPB + 2);
        run_frame({2'b10, 10'd52, 10'd999}, -1, -1);

        // column/row boundaries
        run_frame({2'b11, 10'd1,  10'd9},    -1, -1);
        run_frame({2'b01, 10'd26, 10'd10},   -1, -1);
        run_frame({2'b10, 10'd27, 10'd99},   -1, -1);
        run_frame({2'b11, 10'd53, 10'd100},  -1, -1);
        run_frame({2'b01, 10'd5,  10'd1000}, -1, -1);
        run_frame({2'b10, 10'd12, 10'd100},  -1, -1);

        for (int r = 0; r < 24; r++) begin
            mv[21:20] = 2'($urandom_range(0, 3));
            mv[19:10] = 10'($urandom_range(0, 60));
            mv[9:0]   = 10'($urandom_range(0, 1023));
            run_frame(mv, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trax_move_tx.md
TRAX_MOVE_TX -- requirements
Module: trax_move_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter: MAX_CHARS, default 7, depth of the ASCII character buffer.
REQ-003 Port: clk  input  1  system clock; single clock domain, all logic on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: move_in  input  22  move word: [21:20] tile type (01 plus, 10 slash, 11 bslash), [19:10] column, [9:0] row.
REQ-006 Port: start_transmit  input  1  one-cycle request; move_in is sampled in the same cycle.
REQ-007 Port: tx  output  1  UART serial line, idle high.
REQ-008 Port: busy  output  1  high from the cycle after acceptance until done.
REQ-009 Port: done  output  1  one-cycle pulse after the last stop bit.
REQ-010 Port: err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-011 A request is accepted only when start_transmit=1 and state=IDLE; start_transmit while busy is ignored, with no queuing and no err.
REQ-012 On acceptance, move_in is latched; later changes to move_in do not affect the frame in flight.
REQ-013 Rejection: type=00, column>52 or row>999 -> err pulses the cycle after acceptance; tx stays high; busy stays low; return to IDLE.
REQ-014 States: IDLE -> FMT_COL -> FMT_ROW -> LOAD -> START -> DATA -> [PARITY] -> STOP -> (LOAD if chars remain, else DONE) -> IDLE.
REQ-015 Column encoding:
- 0 -> '@' (0x40).
- 1..26 -> 'A'+col-1.
- 27..52 -> two chars, 'A' then 'A'+col-27.
REQ-016 Row encoding: decimal ASCII, most-significant first, no leading zeros; row 0 -> '0'.
REQ-017 Row conversion uses sequential repeated subtraction of 100 then 10, one subtraction per cycle; FMT_ROW completes in at most 20 cycles; no divider.
REQ-018 Type character: plus '+' (0x2B), slash '/' (0x2F), bslash '\' (0x5C).
REQ-019 Frame: column chars, row digits, type char, then LF (0x0A); 4..7 characters.
REQ-020 Each character is sent LSB first as 1 start bit (0), 8 data bits and 1 stop bit (1); each bit holds for exactly CLKS_PER_BIT cycles.
REQ-021 Characters are sent back to back, with no idle bits between the stop bit and the next start bit.
REQ-022 The first start bit begins no later than 24 cycles after acceptance.
REQ-023 done pulses in the DONE cycle; busy falls in the same cycle.
REQ-024 A new start_transmit is accepted no earlier than the cycle after DONE.
REQ-025 The bit counter and the baud counter are sized to hold CLKS_PER_BIT-1 and 8 without overflow; the baud counter wraps to 0 at each bit boundary.

Reset
REQ-026 While reset=1: state=IDLE, tx=1, busy=0, done=0, err=0, all counters and buffer pointers are 0.
REQ-027 Reset asserted mid-frame aborts the frame: tx=1 on the cycle after the reset edge, with no partial character completed and no done pulse.
REQ-028 reset has priority over a simultaneous start_transmit.

Configuration
REQ-029 Macro TRAX_TX_PARITY_EN:
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted in state PARITY between bit 7 and the stop bit (8E1, 11 bit-times per character).
- Undefined: the PARITY state and its logic are absent (8N1, 10 bit-times per character).

Verification
REQ-030 move_in={01,col 2,row 5}, start pulse -> bytes 0x42 '5' '+' 0x0A; done after 40*CLKS_PER_BIT(+setup) cycles in 8N1.
REQ-031 move_in={10,col 0,row 0} -> bytes 0x40 0x30 0x2F 0x0A.
REQ-032 move_in={11,col 30,row 907} -> bytes 'A' 'D' '9' '0' '7' 0x5C 0x0A (7 chars); the second start_transmit mid-frame is ignored and a single done pulse results.
REQ-033 move_in={00,col 1,row 1} -> err pulse; tx held high; no done; the following valid request is then accepted normally.
REQ-034 Reset asserted during the data bits of the 2nd char -> tx=1 and busy=0 next cycle; subsequent request frames correctly.
REQ-035 With TRAX_TX_PARITY_EN: byte '+' (0x2B, four ones) -> parity bit 0; byte 'B' (0x42, two ones) -> parity bit 0; byte '0' (0x30, two ones) -> parity bit 0; byte '7' (0x37, five ones) -> parity bit 1.
